xoodoo_perm_arbiter: RTL and testbench
======================================

Name: xoodoo_perm_arbiter

Overview:
- Shares one XOODOO permutation core between two requesters (e.g. absorb/squeeze engine and MAC engine) using round-robin arbitration.
- Accepts a 384-bit state from the granted requester and launches the core with a single enable pulse.
- Waits for the core's done pulse, then returns the permuted state to the same requester over a valid/ready response channel.
- Guards each job with a watchdog timeout.

Parameters:
- STATE_W, 384, permutation state width in bits.
- TIMEOUT_CYCLES, 64, max cycles in WAIT before a timeout is declared (must be >= 2).
- CNT_W, 7, width of the watchdog counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a state to permute.
- req0_state  in  STATE_W  requester 0 input state.
- req0_ready  out  1  requester 0 input accepted this cycle.
- rsp0_valid  out  1  permuted state available for requester 0.
- rsp0_state  out  STATE_W  permuted state for requester 0.
- rsp0_ready  in  1  requester 0 consumes the response.
- req1_valid, req1_state, req1_ready, rsp1_valid, rsp1_state, rsp1_ready: same as requester 0, for requester 1.
- perm_enable  out  1  one-cycle launch pulse to the core.
- perm_state_in  out  STATE_W  state presented to the core.
- perm_done  in  1  core completion pulse.
- perm_state_out  in  STATE_W  core result, valid while perm_done=1.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester owning the current job.
- timeout_err  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high) dominates everything, including mid-job. After reset:
  - state = IDLE; all ready/valid outputs = 0; perm_enable = 0; busy = 0; grant_id = 0; timeout_err = 0.
  - last_served = 1, so requester 0 wins the first tie.
  - hold and result registers = 0.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester != last_served.
  - reqN_ready = 1 combinationally for the granted N only. Handshake completes the same cycle.
  - On handshake: latch reqN_state into the hold register, set grant_id = N, go to LAUNCH.
- LAUNCH:
  - perm_enable = 1 for exactly this one cycle.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - perm_enable = 0; counter increments each cycle.
  - On perm_done = 1: latch perm_state_out into the result register, go to RESP.
  - If counter == TIMEOUT_CYCLES-1 and perm_done = 0: set timeout_err, set last_served = grant_id, go to IDLE. No response is issued.
  - If perm_done arrives on the final counter cycle, done wins; no timeout.
- RESP:
  - rspN_valid = 1 for N = grant_id only; rspN_state = result register, stable until the handshake.
  - On rspN_ready = 1: last_served = grant_id, go to IDLE.
  - A new request can be accepted the following cycle at the earliest.
- perm_state_in = hold register at all times. It is stable from LAUNCH through WAIT, as the core requires its input held until done.
- perm_done outside WAIT is ignored: no state change, result register unchanged.
- rspN_state of the non-granted requester = 0.
- New requests arriving while busy are not acknowledged; requesters must hold valid and state until ready.
- Minimum job turnaround, from request accept to response valid: 2 + D cycles, where D = cycles from perm_enable to perm_done, counted from the WAIT entry cycle.

Test Plan:
- Single request: after reset, req0_valid with state = 384'h1 → req0_ready same cycle; perm_enable high exactly one cycle next cycle with perm_state_in = 384'h1. Core model pulses done with 384'hABCD after 14 cycles → rsp0_valid with 384'hABCD, held until rsp0_ready.
- Tie and fairness: both valids held continuously with 3 jobs run → grant order 0,1,0; req1_ready never asserts during requester 0's job.
- Backpressure: rsp1_ready held low 10 cycles → rsp1_valid and rsp1_state stable for all 10, busy = 1, req0 not acknowledged. Release → IDLE next cycle.
- Timeout: TIMEOUT_CYCLES = 8, core never sends done → timeout_err = 1 after 8 WAIT cycles, FSM back in IDLE, no rsp valid. A subsequent job completes normally and timeout_err stays 1.
- Spurious and boundary done: perm_done pulsed in IDLE → no effect. perm_done on the 8th WAIT cycle (TIMEOUT_CYCLES = 8) → response issued, timeout_err = 0.
- Reset mid-WAIT: assert reset for 1 cycle → next cycle busy = 0, perm_enable = 0, all ready/valid = 0; a later done pulse is ignored; the next tie is granted to requester 0.

Source files
------------

// File: rtl/xoodoo_perm_arbiter.sv
// Round-robin arbiter sharing one XOODOO permutation core between two requesters.
// Each job: accept state, pulse the core, wait for done (watchdog-guarded), return the result.
module xoodoo_perm_arbiter #(
  parameter int STATE_W        = 384,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [STATE_W-1:0] req0_state,
  output logic               req0_ready,
  output logic               rsp0_valid,
  output logic [STATE_W-1:0] rsp0_state,
  input  logic               rsp0_ready,
  input  logic               req1_valid,
  input  logic [STATE_W-1:0] req1_state,
  output logic               req1_ready,
  output logic               rsp1_valid,
  output logic [STATE_W-1:0] rsp1_state,
  input  logic               rsp1_ready,
  output logic               perm_enable,
  output logic [STATE_W-1:0] perm_state_in,
  input  logic               perm_done,
  input  logic [STATE_W-1:0] perm_state_out,
  output logic               busy,
  output logic               grant_id,
  output logic               timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic               last_served;
  logic [STATE_W-1:0] hold_q;
  logic [STATE_W-1:0] result_q;
  logic [CNT_W-1:0]   wdog_cnt;
  logic               pick;
  logic               accept;
  logic               rsp_ready_sel;

  // On a tie the requester that was not served last wins; otherwise whoever is asking.
  assign pick = (req0_valid && req1_valid) ? ~last_served : req1_valid;

  // NOTE: ready is combinational so the request handshake completes in the same IDLE cycle.
  assign req0_ready = (state == ST_IDLE) && req0_valid && !pick;
  assign req1_ready = (state == ST_IDLE) && req1_valid &&  pick;
  assign accept     = req0_ready || req1_ready;

  assign rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;
  assign rsp0_valid    = (state == ST_RESP) && !grant_id;
  assign rsp1_valid    = (state == ST_RESP) &&  grant_id;
  assign rsp0_state    = grant_id ? '0 : result_q;
  assign rsp1_state    = grant_id ? result_q : '0;

  // The core needs its input held until done, so it sees the hold register directly.
  assign perm_state_in = hold_q;
  assign busy          = (state != ST_IDLE);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
      grant_id    <= 1'b0;
      perm_enable <= 1'b0;
      timeout_err <= 1'b0;
      wdog_cnt    <= '0;
      // NOTE: the wide data registers are reset too so an idle response port reads all-zero.
      hold_q      <= '0;
      result_q    <= '0;
    end else begin
      perm_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold_q      <= pick ? req1_state : req0_state;
            grant_id    <= pick;
            perm_enable <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wdog_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wdog_cnt <= wdog_cnt + CNT_W'(1);
          // done on the final watchdog cycle still counts as success
          if (perm_done) begin
            result_q <= perm_state_out;
            state    <= ST_RESP;
          end else if (wdog_cnt == WDOG_LAST) begin
            timeout_err <= 1'b1;
            last_served <= grant_id;
            state       <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready_sel) begin
            last_served <= grant_id;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_perm_arbiter.sv
// Directed bench for xoodoo_perm_arbiter: instance a uses a 64-cycle watchdog, instance b an 8-cycle one.
// Both share stimulus; sel chooses which instance the scenario tasks observe.
module tb_xoodoo_perm_arbiter;
  localparam int W = 384;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, rsp0_ready, rsp1_ready, perm_done;
  logic [W-1:0] req0_state, req1_state, perm_state_out;

  logic a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_perm_enable, a_busy, a_grant_id, a_timeout_err;
  logic [W-1:0] a_rsp0_state, a_rsp1_state, a_perm_state_in;
  logic b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_perm_enable, b_busy, b_grant_id, b_timeout_err;
  logic [W-1:0] b_rsp0_state, b_rsp1_state, b_perm_state_in;

  always #5 clk = ~clk;

  xoodoo_perm_arbiter #(.STATE_W(W), .TIMEOUT_CYCLES(64), .CNT_W(7)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_state(req0_state), .req0_ready(a_req0_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_state(a_rsp0_state), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_state(req1_state), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_state(a_rsp1_state), .rsp1_ready(rsp1_ready),
    .perm_enable(a_perm_enable), .perm_state_in(a_perm_state_in),
    .perm_done(perm_done), .perm_state_out(perm_state_out),
    .busy(a_busy), .grant_id(a_grant_id), .timeout_err(a_timeout_err)
  );

  xoodoo_perm_arbiter #(.STATE_W(W), .TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_state(req0_state), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_state(b_rsp0_state), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_state(req1_state), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_state(b_rsp1_state), .rsp1_ready(rsp1_ready),
    .perm_enable(b_perm_enable), .perm_state_in(b_perm_state_in),
    .perm_done(perm_done), .perm_state_out(perm_state_out),
    .busy(b_busy), .grant_id(b_grant_id), .timeout_err(b_timeout_err)
  );

  logic sel;
  logic s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_perm_enable, s_busy, s_grant_id, s_timeout_err;
  logic [W-1:0] s_rsp0_state, s_rsp1_state, s_perm_state_in;
  assign s_req0_ready    = sel ? b_req0_ready    : a_req0_ready;
  assign s_req1_ready    = sel ? b_req1_ready    : a_req1_ready;
  assign s_rsp0_valid    = sel ? b_rsp0_valid    : a_rsp0_valid;
  assign s_rsp1_valid    = sel ? b_rsp1_valid    : a_rsp1_valid;
  assign s_perm_enable   = sel ? b_perm_enable   : a_perm_enable;
  assign s_busy          = sel ? b_busy          : a_busy;
  assign s_grant_id      = sel ? b_grant_id      : a_grant_id;
  assign s_timeout_err   = sel ? b_timeout_err   : a_timeout_err;
  assign s_rsp0_state    = sel ? b_rsp0_state    : a_rsp0_state;
  assign s_rsp1_state    = sel ? b_rsp1_state    : a_rsp1_state;
  assign s_perm_state_in = sel ? b_perm_state_in : a_perm_state_in;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  bit ready_leak;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance one cycle; inputs are driven at posedge+1, outputs checked from posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_busy && (s_req0_ready || s_req1_ready)) ready_leak = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    perm_done = 1'b0; req0_state = '0; req1_state = '0; perm_state_out = '0;
    tick(); tick();
    reset = 1'b0;
    ready_leak = 1'b0;
  endtask

  task automatic accept(input bit id, input logic [W-1:0] exp_in);
    #1;
    n_checks++;
    if ({s_req1_ready, s_req0_ready} !== (id ? 2'b10 : 2'b01))
      $display("FAIL accept_ready: got r1r0=%b%b want id %0d", s_req1_ready, s_req0_ready, id);
    else n_pass++;
    t_acc = cyc;
    tick();
    n_checks++;
    if (s_perm_enable !== 1'b1 || s_perm_state_in !== exp_in || s_grant_id !== id || s_busy !== 1'b1)
      $display("FAIL launch: en=%b grant=%b busy=%b state_in=%h want state_in=%h grant=%0d",
               s_perm_enable, s_grant_id, s_busy, s_perm_state_in, exp_in, id);
    else n_pass++;
  endtask

  task automatic finish_core(input bit id, input int d, input logic [W-1:0] res);
    logic [W-1:0] mine, other;
    tick();
    n_checks++;
    if (s_perm_enable !== 1'b0 || s_busy !== 1'b1)
      $display("FAIL wait_entry: en=%b busy=%b want en=0 busy=1", s_perm_enable, s_busy);
    else n_pass++;
    repeat (d - 1) tick();
    perm_done = 1'b1; perm_state_out = res;
    tick();
    perm_done = 1'b0; perm_state_out = '0;
    #1;
    mine  = id ? s_rsp1_state : s_rsp0_state;
    other = id ? s_rsp0_state : s_rsp1_state;
    n_checks++;
    if ({s_rsp1_valid, s_rsp0_valid} !== (id ? 2'b10 : 2'b01) || mine !== res || other !== '0)
      $display("FAIL resp: valid=%b%b state=%h other=%h want state=%h", s_rsp1_valid, s_rsp0_valid, mine, other, res);
    else n_pass++;
    n_checks++;
    if (cyc - t_acc !== d + 2)
      $display("FAIL turnaround: got %0d cycles want %0d", cyc - t_acc, d + 2);
    else n_pass++;
  endtask

  task automatic respond(input bit id, input logic [W-1:0] res, input int bp);
    bit bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      if ({s_rsp1_valid, s_rsp0_valid} !== (id ? 2'b10 : 2'b01) || s_busy !== 1'b1 ||
          (id ? s_rsp1_state : s_rsp0_state) !== res)
        bad = 1'b1;
      tick();
    end
    if (bp > 0) begin
      n_checks++;
      if (bad) $display("FAIL resp_backpressure: response not held stable over %0d cycles", bp);
      else n_pass++;
    end
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_rsp0_valid !== 1'b0 || s_rsp1_valid !== 1'b0)
      $display("FAIL resp_release: busy=%b valid=%b%b want all 0", s_busy, s_rsp1_valid, s_rsp0_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_perm_enable !== 1'b0 || s_grant_id !== 1'b0 || s_timeout_err !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b en=%b grant=%b terr=%b want 0000", s_busy, s_perm_enable, s_grant_id, s_timeout_err);
    else n_pass++;
    n_checks++;
    if ({s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid} !== 4'b0000)
      $display("FAIL reset_handshake: got %b want 0000", {s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid});
    else n_pass++;
    n_checks++;
    if (s_perm_state_in !== '0 || s_rsp0_state !== '0 || s_rsp1_state !== '0)
      $display("FAIL reset_data: state_in=%h rsp0=%h rsp1=%h want 0", s_perm_state_in, s_rsp0_state, s_rsp1_state);
    else n_pass++;
  endtask

  task automatic test_single();
    sel = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_state = W'(1);
    accept(1'b0, W'(1));
    req0_valid = 1'b0; req0_state = W'(32'h5555);
    finish_core(1'b0, 14, W'(16'hABCD));
    n_checks++;
    if (s_perm_state_in !== W'(1))
      $display("FAIL hold_stable: state_in=%h want 1", s_perm_state_in);
    else n_pass++;
    respond(1'b0, W'(16'hABCD), 3);
  endtask

  task automatic test_tie_fairness();
    sel = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_state = W'(8'h10);
    req1_valid = 1'b1; req1_state = W'(8'h20);
    accept(1'b0, W'(8'h10)); finish_core(1'b0, 3, W'(16'h1111)); respond(1'b0, W'(16'h1111), 0);
    accept(1'b1, W'(8'h20)); finish_core(1'b1, 4, W'(16'h2222)); respond(1'b1, W'(16'h2222), 0);
    accept(1'b0, W'(8'h10)); finish_core(1'b0, 2, W'(16'h3333)); respond(1'b0, W'(16'h3333), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (ready_leak) $display("FAIL tie_ready_leak: got a ready while busy want none");
    else n_pass++;
  endtask

  task automatic test_back_to_back_backpressure();
    sel = 1'b0;
    do_reset();
    req1_valid = 1'b1; req1_state = W'(8'h55);
    accept(1'b1, W'(8'h55));
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_state = W'(8'h66);
    finish_core(1'b1, 3, W'(16'h7777));
    respond(1'b1, W'(16'h7777), 10);
    n_checks++;
    if (s_req0_ready !== 1'b1 || s_req1_ready !== 1'b0)
      $display("FAIL idle_after_release: r0=%b r1=%b want r0=1 r1=0", s_req0_ready, s_req1_ready);
    else n_pass++;
    n_checks++;
    if (ready_leak) $display("FAIL bp_ready_leak: req0 acknowledged while busy");
    else n_pass++;
    req0_valid = 1'b0;
  endtask

  task automatic test_timeout();
    bit bad = 1'b0;
    sel = 1'b1;
    do_reset();
    req0_valid = 1'b1; req0_state = W'(3);
    accept(1'b0, W'(3));
    req0_valid = 1'b0;
    tick();
    for (int k = 1; k < 8; k++) begin
      tick();
      if (s_busy !== 1'b1 || s_timeout_err !== 1'b0 || s_rsp0_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL timeout_early: watchdog fired or left WAIT before 8 cycles");
    else n_pass++;
    tick();
    n_checks++;
    if (s_timeout_err !== 1'b1 || s_busy !== 1'b0 || s_rsp0_valid !== 1'b0 || s_rsp1_valid !== 1'b0)
      $display("FAIL timeout_fire: terr=%b busy=%b valid=%b%b want 1 0 00", s_timeout_err, s_busy, s_rsp1_valid, s_rsp0_valid);
    else n_pass++;
    req0_valid = 1'b1; req0_state = W'(4);
    accept(1'b0, W'(4));
    req0_valid = 1'b0;
    finish_core(1'b0, 5, W'(8'h44));
    respond(1'b0, W'(8'h44), 0);
    n_checks++;
    if (s_timeout_err !== 1'b1) $display("FAIL timeout_sticky: terr=%b want 1", s_timeout_err);
    else n_pass++;
  endtask

  task automatic test_spurious_boundary_done();
    sel = 1'b1;
    do_reset();
    perm_done = 1'b1; perm_state_out = W'(16'hDEAD);
    tick();
    perm_done = 1'b0; perm_state_out = '0;
    tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_rsp0_valid !== 1'b0 || s_rsp0_state !== '0)
      $display("FAIL spurious_done: busy=%b valid=%b rsp0=%h want 0 0 0", s_busy, s_rsp0_valid, s_rsp0_state);
    else n_pass++;
    req0_valid = 1'b1; req0_state = W'(9);
    accept(1'b0, W'(9));
    req0_valid = 1'b0;
    finish_core(1'b0, 8, W'(16'hBEEF));
    n_checks++;
    if (s_timeout_err !== 1'b0) $display("FAIL boundary_done: terr=%b want 0", s_timeout_err);
    else n_pass++;
    respond(1'b0, W'(16'hBEEF), 0);
  endtask

  task automatic test_reset_mid_wait();
    sel = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_state = W'(8'hA1);
    accept(1'b0, W'(8'hA1));
    req0_valid = 1'b0;
    finish_core(1'b0, 2, W'(8'hB1));
    respond(1'b0, W'(8'hB1), 0);
    req0_valid = 1'b1; req0_state = W'(8'hA2);
    accept(1'b0, W'(8'hA2));
    req0_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_perm_enable !== 1'b0 ||
        {s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid} !== 4'b0000)
      $display("FAIL mid_reset: busy=%b en=%b hs=%b want 0 0 0000", s_busy, s_perm_enable,
               {s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid});
    else n_pass++;
    perm_done = 1'b1; perm_state_out = W'(16'hFEED);
    tick();
    perm_done = 1'b0; perm_state_out = '0;
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_rsp0_valid !== 1'b0 || s_rsp0_state !== '0)
      $display("FAIL late_done: busy=%b valid=%b rsp0=%h want 0 0 0", s_busy, s_rsp0_valid, s_rsp0_state);
    else n_pass++;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if (s_req0_ready !== 1'b1 || s_req1_ready !== 1'b0)
      $display("FAIL tie_after_reset: r0=%b r1=%b want r0=1 r1=0", s_req0_ready, s_req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_fairness();
    test_back_to_back_backpressure();
    test_timeout();
    test_spurious_boundary_done();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1, "bench timed out");
  end

endmodule
